addsub_seq_ctrl: RTL

//  Multi-cycle sequencer that time-shares one CHUNK-bit add/sub slice across a WIDTH-bit operation.

---
 rtl/addsub_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: time-shares one CHUNK-bit add/sub slice across a WIDTH-bit
// operation, LSB chunk first, forwarding the carry between chunks.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on the start edge
// RUN    | one chunk processed per edge; the last chunk publishes results
// DONE   | done pulse cycle; start is ignored here, back to IDLE next edge
module addsub_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bi_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] bi_chunk;
  logic [CHUNK:0]   sum_w;
  logic [WIDTH-1:0] work_d;
  logic             last_w;
  logic             ovf_d;

  // Shared slice: select the current chunk, add it, and merge it into the work word.
  always_comb begin
    a_chunk  = '0;
    bi_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk  = a_q[k*CHUNK +: CHUNK];
        bi_chunk = bi_q[k*CHUNK +: CHUNK];
      end
    end
    sum_w  = {1'b0, a_chunk} + {1'b0, bi_chunk} + {{CHUNK{1'b0}}, carry_q};
    work_d = work_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        work_d[k*CHUNK +: CHUNK] = sum_w[CHUNK-1:0];
      end
    end
    last_w = (cnt_q == CW'(NCHUNK - 1));
    ovf_d  = (a_q[WIDTH-1] == bi_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Sequencer FSM with registered results; partial sums stay in work_q only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      bi_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            bi_q    <= b ^ {WIDTH{op}};
            carry_q <= op;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          work_q  <= work_d;
          carry_q <= sum_w[CHUNK];
          if (last_w) begin
            cnt_q    <= '0;
            result_q <= work_d;
            cout_q   <= sum_w[CHUNK];
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
